// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer and its register file.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_RAW   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Arithmetic group 000-011, logic group 100-111
  localparam logic [2:0] OP_000 = 3'b000;
  localparam logic [2:0] OP_001 = 3'b001;
  localparam logic [2:0] OP_010 = 3'b010;
  localparam logic [2:0] OP_011 = 3'b011;
  localparam logic [2:0] OP_100 = 3'b100;
  localparam logic [2:0] OP_101 = 3'b101;
  localparam logic [2:0] OP_110 = 3'b110;
  localparam logic [2:0] OP_111 = 3'b111;

endpackage

// File: rtl/alu_regfile.sv
// NREG x WIDTH register file: two asynchronous read ports, one synchronous write port.
module alu_regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RAW-1:0]   raddr_a,
  input  logic [RAW-1:0]   raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [NREG];

  // NOTE: this storage is cleared on reset because software relies on every
  // register reading 0 afterwards; larger memories would normally skip this.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Serialises register-based commands onto an external combinational ALU and
// returns each result (or load value) over a valid/ready response port.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = 4,
  parameter int RAW   = DEF_RAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [RAW-1:0]   cmd_dst,
  input  logic [RAW-1:0]   cmd_src_a,
  input  logic [RAW-1:0]   cmd_src_b,
  input  logic             cmd_imm_sel,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             carry_flag
);

  state_t           state;
  logic [RAW-1:0]   dst_q;
  logic             cmd_fire;
  logic             rf_we;
  logic [RAW-1:0]   rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign cmd_fire = cmd_valid && cmd_ready;

  // Write port is shared: immediate loads write in IDLE, ALU results in EXEC.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = cmd_dst;
    rf_wdata = cmd_imm;
    if (state == IDLE && cmd_fire && cmd_load) begin
      rf_we = 1'b1;
    end else if (state == EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = dst_q;
      rf_wdata = alu_y;
    end
  end

  alu_regfile #(.WIDTH(WIDTH), .NREG(NREG), .RAW(RAW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_src_a),
    .raddr_b (cmd_src_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      dst_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_cout   <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cmd_ready <= 1'b0;
            if (cmd_load) begin
              rsp_y     <= cmd_imm;
              rsp_cout  <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_a  <= rd_a;
              alu_b  <= cmd_imm_sel ? cmd_imm : rd_b;
              alu_op <= cmd_op;
              dst_q  <= cmd_dst;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_y      <= alu_y;
          rsp_cout   <= alu_cout;
          carry_flag <= alu_cout;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Command sequencer that drives the 16-bit, 3-bit-opcode ALU datapath. It accepts register-based ALU commands over a valid/ready port and drives the external ALU's a/b/op inputs from a small register file or an immediate. It captures y/cout, writes the result back and returns it over a valid/ready response port. It sits between a host or test driver and the combinational ALU, so the ALU is shared through one serialized command stream.

Parameters:
WIDTH, 16, datapath width; must match the ALU operand width
NREG, 4, register-file entries
RAW, 2, register address width; equals log2(NREG)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_load  input  1  1 = write cmd_imm to cmd_dst, no ALU use
cmd_op  input  3  ALU opcode passed to alu_op
cmd_dst  input  RAW  destination register
cmd_src_a  input  RAW  operand A register
cmd_src_b  input  RAW  operand B register
cmd_imm_sel  input  1  1 = operand B is cmd_imm
cmd_imm  input  WIDTH  immediate value
alu_a  output  WIDTH  ALU operand a
alu_b  output  WIDTH  ALU operand b
alu_op  output  3  ALU opcode
alu_y  input  WIDTH  ALU result
alu_cout  input  1  ALU carry out
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_y  output  WIDTH  result (load value or ALU y)
rsp_cout  output  1  carry; 0 for load commands
carry_flag  output  1  sticky copy of last ALU cout

Behaviour:
- Reset: one clock and one synchronous active-low reset (rst_n), sampled on the rising edge of clk. Effects:
  - state = IDLE
  - all registers = 0
  - alu_a/alu_b/alu_op = 0
  - rsp_valid = 0, rsp_y = 0, rsp_cout = 0, carry_flag = 0
  - cmd_ready = 1 on the first cycle after reset is released
- State IDLE:
  - cmd_ready = 1.
  - Handshake on cmd_valid & cmd_ready.
  - Load command: write regfile[dst] = cmd_imm, rsp_y = cmd_imm, rsp_cout = 0; go to RESP.
  - ALU command: register alu_a = reg[src_a], alu_b = cmd_imm_sel ? cmd_imm : reg[src_b], alu_op = cmd_op, and latch dst; go to EXEC.
- State EXEC (exactly 1 cycle, ALU settles combinationally):
  - cmd_ready = 0.
  - At the end of the cycle, capture rsp_y = alu_y and rsp_cout = alu_cout.
  - Write regfile[dst] = alu_y and carry_flag = alu_cout; go to RESP.
- State RESP:
  - rsp_valid = 1; rsp_y/rsp_cout are held stable while rsp_valid & !rsp_ready.
  - On rsp_ready: go to IDLE and clear rsp_valid next cycle.
  - If rsp_ready is already high when rsp_valid rises, the handshake completes that cycle.
- Latency, cmd handshake to rsp_valid: 2 cycles for ALU commands, 1 cycle for loads.
- Throughput: one command per 3 cycles (ALU) or 2 cycles (load) with rsp_ready tied high.
- Commands are serialized, so a command reading the previous command's dst sees the written value. No hazards exist.
- src_a == src_b == dst is legal. Operands are read before the writeback.
- alu_a/alu_b/alu_op hold their last values outside EXEC. There is no glitching toggle.
- carry_flag is updated only by ALU commands; loads leave it unchanged.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded and no writeback occurs. The reset edge overrides the EXEC write.
- cmd_* inputs are ignored while cmd_ready = 0.

Decomposition:
- Package alu_ctrl_pkg:
  - state localparams IDLE=2'd0, EXEC=2'd1, RESP=2'd2
  - opcode constants OP_000..OP_111 (arithmetic 000-011, logic 100-111)
  - WIDTH and RAW defaults
- Sub-module alu_regfile: NREG x WIDTH, 2 async read ports, 1 sync write port, synchronous active-low clear.
- The ALU itself stays outside this block. The bench instantiates it or a stub.

Test Plan:
The bench ALU stub computes y = a + b with cout = carry for op 000, and y = a ^ b with cout = 0 for all other ops.
1. Load r0=16'h8F54, then load r1=16'h79F8 -> each response gives rsp_y equal to the immediate, rsp_cout=0, rsp_valid 1 cycle after the handshake.
2. ALU op=000, src_a=r0, src_b=r1, dst=r2 -> alu_a=8F54, alu_b=79F8 during EXEC; rsp_y=16'h094C, rsp_cout=1, carry_flag=1; a subsequent read of r2 gives 094C.
3. ALU op=100, src_a=r2, imm_sel=1, imm=16'hFFFF, dst=r2 -> rsp_y=16'hF6B3, carry_flag clears to 0, r2=F6B3.
4. Hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_y stable, cmd_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
5. Back-to-back commands with rsp_ready tied high -> one ALU command accepted every 3 cycles, one load every 2 cycles.
6. Assert rst_n=0 during EXEC of a command with dst=r3 -> r3 stays 0, rsp_valid=0, carry_flag=0, state IDLE.
